tt_sweep_capture: RTL

Exhaustive stimulus and capture stage that sits directly upstream of a 7-input single-output Boolean function block (majority-gate network under classification). It drives the function's inputs x0..x6 through all 128 minterms in ascending order, samples the function output, and assembles the 128-bit truth table. The captured table is compared against a 128-bit expected hex signature, and the block reports a match flag, mismatch count and lowest mismatching minterm.

---
 rtl/tt_sweep_capture.sv | 122 ++++++++++++
 1 files changed

// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: walks a 7-input function block through all 128 minterms,
// captures its output into a truth table and compares it with a reference.
module tt_sweep_capture #(
    parameter int LAT = 0  // cycles from x to a valid f_in (0..7)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] expected,
    output logic [6:0]   x,
    input  logic         f_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] tt,
    output logic         match,
    output logic [7:0]   mismatch_count,
    output logic [6:0]   first_mismatch
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t       state, state_nxt;
    logic [6:0]   cnt;        // minterm index in SWEEP, drain cycle in DRAIN
    logic [127:0] exp_q;
    logic         vld0;
    logic [6:0]   j0;
    logic         cap_vld;
    logic [6:0]   cap_j;
    logic         mism;
    logic [7:0]   count_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; the sweep skips DRAIN when the function is combinational
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SWEEP;
            SWEEP:   if (cnt == 7'd127) state_nxt = (LAT == 0) ? DONE : DRAIN;
            DRAIN:   if (cnt == 7'(LAT - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared counter restarts on every state change
    always_ff @(posedge clk) begin
        if (!rst_n)                                 cnt <= '0;
        else if (state_nxt != state)                cnt <= '0;
        else if (state == SWEEP || state == DRAIN)  cnt <= cnt + 7'd1;
    end

    assign x    = (state == SWEEP) ? cnt : 7'd0;
    assign busy = (state == SWEEP) || (state == DRAIN);
    assign done = (state == DONE);

    // Tag of the minterm presented this cycle
    assign vld0 = (state == SWEEP);
    assign j0   = cnt;

    generate
        if (LAT == 0) begin : g_comb
            assign cap_vld = vld0;
            assign cap_j   = j0;
        end else begin : g_pipe
            logic [LAT-1:0]      vld_pipe;
            logic [LAT-1:0][6:0] j_pipe;

            // Tag delay line matching the function block latency
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                    j_pipe   <= '0;
                end else begin
                    vld_pipe[0] <= vld0;
                    j_pipe[0]   <= j0;
                    for (int k = 1; k < LAT; k++) begin
                        vld_pipe[k] <= vld_pipe[k-1];
                        j_pipe[k]   <= j_pipe[k-1];
                    end
                end
            end

            assign cap_vld = vld_pipe[LAT-1];
            assign cap_j   = j_pipe[LAT-1];
        end
    endgenerate

    // Count saturates at 128 so it can never wrap in 8 bits
    assign mism      = cap_vld && (f_in != exp_q[cap_j]) && (mismatch_count != 8'd128);
    assign count_nxt = mismatch_count + {7'd0, mism};

    // Capture, compare and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q          <= '0;
            tt             <= '0;
            match          <= 1'b0;
            mismatch_count <= '0;
            first_mismatch <= '0;
        end else if (state == IDLE && start) begin
            exp_q          <= expected;
            tt             <= '0;
            match          <= 1'b0;
            mismatch_count <= '0;
            first_mismatch <= '0;
        end else begin
            if (cap_vld) tt[cap_j] <= f_in;
            if (mism) begin
                mismatch_count <= count_nxt;
                if (mismatch_count == 8'd0) first_mismatch <= cap_j;
            end
            // Final capture lands on the same edge that enters DONE
            if (state_nxt == DONE && state != DONE) match <= (count_nxt == 8'd0);
        end
    end

endmodule
